mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 170 +++++++++++++++++
 tb/tb_mdu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multiply/divide unit that owns the architectural HI/LO pair.
// Multi-cycle ops (mult/multu: 5 cycles, div/divu: 10 cycles) latch their
// operands on issue. Results are written to HI/LO on the edge where busy falls.
// Optional build macro: MDU_MADD_EN enables madd/maddu/msub/msubu (5 cycles).
module mdu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        md_start,
   output logic        busy,
   output logic [31:0] hilo_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } opCode_t;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   state_t      state;
   logic [3:0]  count;
   logic [3:0]  opReg;
   logic [31:0] rsReg;
   logic [31:0] rtReg;

   logic        isMulti;
   logic [3:0]  loadCount;

   logic signed [63:0] mulA, mulB, prodS;
   logic [63:0]        prodU;
   logic signed [32:0] dvdS, dvsS;
   logic [31:0]        quoS, remS, quoU, remU;
   logic [63:0]        result;
   logic               resValid;

   assign busy     = (state == S_BUSY);
   assign md_start = isMulti & ~busy;

   // Decode which ops start a multi-cycle operation and their busy length.
   always_comb begin
      isMulti   = 1'b0;
      loadCount = '0;
      case (md_op)
         OP_MULT, OP_MULTU: begin
            isMulti   = 1'b1;
            loadCount = 4'd5;
         end
         OP_DIV, OP_DIVU: begin
            isMulti   = 1'b1;
            loadCount = 4'd10;
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            isMulti   = 1'b1;
            loadCount = 4'd5;
         end
`endif
         default: ;
      endcase
   end

   // Forwarding read port for mfhi/mflo; independent of busy.
   always_comb begin
      case (md_op)
         OP_MFHI: hilo_data = hi;
         OP_MFLO: hilo_data = lo;
         default: hilo_data = '0;
      endcase
   end

   // Arithmetic on the latched operands; the division runs 33 bits wide so
   // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of overflowing.
   always_comb begin
      mulA  = {{32{rsReg[31]}}, rsReg};
      mulB  = {{32{rtReg[31]}}, rtReg};
      prodS = mulA * mulB;
      prodU = {32'b0, rsReg} * {32'b0, rtReg};
      dvdS  = {rsReg[31], rsReg};
      dvsS  = {rtReg[31], rtReg};
      quoS  = 32'(dvdS / dvsS);
      remS  = 32'(dvdS % dvsS);
      quoU  = rtReg == '0 ? '0 : rsReg / rtReg;
      remU  = rtReg == '0 ? '0 : rsReg % rtReg;
   end

   // Select the HI/LO value written at completion; divide by zero keeps HI/LO.
   always_comb begin
      result   = {hi, lo};
      resValid = 1'b1;
      case (opReg)
         OP_MULT:  result = prodS;
         OP_MULTU: result = prodU;
         OP_DIV: begin
            resValid = (rtReg != '0);
            result   = {remS, quoS};
         end
         OP_DIVU: begin
            resValid = (rtReg != '0);
            result   = {remU, quoU};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  result = {hi, lo} + prodS;
         OP_MADDU: result = {hi, lo} + prodU;
         OP_MSUB:  result = {hi, lo} - prodS;
         OP_MSUBU: result = {hi, lo} - prodU;
`endif
         default: ;
      endcase
   end

   // Control FSM: accept ops when idle, count down while busy, commit HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         count <= '0;
         opReg <= '0;
         rsReg <= '0;
         rtReg <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (md_start) begin
                  state <= S_BUSY;
                  count <= loadCount;
                  opReg <= md_op;
                  rsReg <= rs_data;
                  rtReg <= rt_data;
               end else if (md_op == OP_MTHI) begin
                  hi <= rs_data;
               end else if (md_op == OP_MTLO) begin
                  lo <= rs_data;
               end
            end
            S_BUSY: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= S_IDLE;
                  if (resValid) begin
                     hi <= result[63:32];
                     lo <= result[31:0];
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and randomized checks of mdu against an arithmetic model.
module tb_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        md_start;
   logic        busy;
   logic [31:0] hilo_data;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;

   mdu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .md_op     (md_op),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .md_start  (md_start),
      .busy      (busy),
      .hilo_data (hilo_data),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned latency(input logic [3:0] op);
      case (op)
         4'd1, 4'd2: return 5;
         4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
         4'd9, 4'd10, 4'd11, 4'd12: return 5;
`endif
         default: return 0;
      endcase
   endfunction

   // Architectural effect of one accepted op on {hi,lo}.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] h,
                                         input logic [31:0] l);
      int                sa, sb;
      longint            ps, q, r;
      longint unsigned   pu;
      logic [63:0]       acc;
      sa  = a;
      sb  = b;
      ps  = longint'(sa) * longint'(sb);
      pu  = longint'({32'b0, a}) * longint'({32'b0, b});
      acc = {h, l};
      case (op)
         4'd1: return ps;
         4'd2: return pu;
         4'd3: begin
            if (b == 0) return acc;
            q = longint'(sa) / longint'(sb);
            r = longint'(sa) % longint'(sb);
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 0) return acc;
            return {a % b, a / b};
         end
         4'd7: return {a, l};
         4'd8: return {h, a};
`ifdef MDU_MADD_EN
         4'd9:  return acc + ps;
         4'd10: return acc + pu;
         4'd11: return acc - ps;
         4'd12: return acc - pu;
`endif
         default: return acc;
      endcase
   endfunction

   // Issue one op at the current cycle, exercise lockout while busy, then
   // check busy timing and the committed HI/LO.
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned n;
      logic [63:0] exp;
      n   = latency(op);
      exp = model(op, a, b, mHi, mLo);
      md_op   = op;
      rs_data = a;
      rt_data = b;
      #1;
      check("md_start_issue", md_start, n != 0);
      check("hilo_issue", hilo_data, op == 4'd5 ? mHi : (op == 4'd6 ? mLo : 32'h0));
      @(posedge clk); #1;
      for (int unsigned i = 1; i <= n; i++) begin
         check("busy_in_flight", busy, 1'b1);
         if (i == 2) begin
            md_op   = 4'd7;
            rs_data = 32'h1234;
         end else if (i == 3) begin
            md_op   = 4'd5;
         end else begin
            md_op   = 4'($urandom_range(0, 15));
            rs_data = $urandom;
         end
         rt_data = $urandom;
         #1;
         check("start_locked", md_start, 1'b0);
         check("hilo_busy", hilo_data,
               md_op == 4'd5 ? mHi : (md_op == 4'd6 ? mLo : 32'h0));
         @(posedge clk); #1;
      end
      md_op = 4'd0;
      check("busy_done", busy, 1'b0);
      {mHi, mLo} = exp;
      check("hi", hi, mHi);
      check("lo", lo, mLo);
   endtask

   initial begin
      logic [31:0] accHi, accLo;
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      rst_n   = 1'b0;
      md_op   = 4'd0;
      rs_data = '0;
      rt_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_start", md_start, 1'b0);
      check("rst_hilo", hilo_data, 32'h0);
      md_op = 4'd1;
      #1;
      check("rst_start_follows", md_start, 1'b1);
      md_op = 4'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // mult -2 * 3
      runOp(4'd1, 32'hFFFFFFFE, 32'd3);
      check("mult_hi_const", hi, 32'hFFFFFFFF);
      check("mult_lo_const", lo, 32'hFFFFFFFA);

      // divu then div
      runOp(4'd4, 32'd7, 32'd2);
      check("divu_hi_const", hi, 32'd1);
      check("divu_lo_const", lo, 32'd3);
      runOp(4'd3, 32'hFFFFFFF9, 32'd2);
      check("div_hi_const", hi, 32'hFFFFFFFF);
      check("div_lo_const", lo, 32'hFFFFFFFD);

      // divide by zero keeps HI/LO
      runOp(4'd7, 32'd5, 32'd0);
      runOp(4'd8, 32'd6, 32'd0);
      runOp(4'd3, 32'd1234, 32'd0);
      check("div0_hi_const", hi, 32'd5);
      check("div0_lo_const", lo, 32'd6);

      // signed overflow case
      runOp(4'd3, 32'h80000000, 32'hFFFFFFFF);
      check("divovf_hi_const", hi, 32'h0);
      check("divovf_lo_const", lo, 32'h80000000);

      // mfhi/mflo and reserved op codes
      runOp(4'd5, 32'hDEAD, 32'hBEEF);
      runOp(4'd6, 32'hDEAD, 32'hBEEF);
      runOp(4'd14, 32'hDEAD, 32'hBEEF);

      // reset during the third busy cycle aborts the op
      runOp(4'd7, 32'hAAAA, 32'd0);
      runOp(4'd8, 32'h5555, 32'd0);
      md_op   = 4'd1;
      rs_data = 32'd7;
      rt_data = 32'd9;
      @(posedge clk); #1;
      md_op = 4'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mHi = '0;
      mLo = '0;
      repeat (12) @(posedge clk);
      #1;
      check("abort_busy_later", busy, 1'b0);
      check("abort_hi_later", hi, 32'h0);
      check("abort_lo_later", lo, 32'h0);

      // accumulate (or its absence in the default build)
      runOp(4'd7, 32'h0, 32'd0);
      runOp(4'd8, 32'hFFFFFFFF, 32'd0);
      runOp(4'd10, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      accHi = 32'd1;
      accLo = 32'd0;
`else
      accHi = 32'd0;
      accLo = 32'hFFFFFFFF;
`endif
      check("acc_hi_const", hi, accHi);
      check("acc_lo_const", lo, accLo);

      // randomized mix
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 9))
            0: rop = 4'd1;
            1: rop = 4'd2;
            2: rop = 4'd3;
            3: rop = 4'd4;
            4: rop = 4'd7;
            5: rop = 4'd8;
            6: rop = 4'd9;
            7: rop = 4'd11;
            8: rop = 4'd12;
            default: rop = 4'd10;
         endcase
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         runOp(rop, ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
